// File: rtl/xb_pkg.sv
// Shared constants and helpers for the Xillybus message-queue blocks.
package xb_pkg;

  localparam int XB_SIZE            = 32;
  localparam int XB_DEF_ADDR_W      = 9;
  localparam int XB_DEF_AFULL_MARGIN = 4;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Which side of the queue moves on a given edge, packed as {write, read}.
  typedef enum logic [1:0] {
    XB_OP_NONE  = 2'b00,
    XB_OP_RD    = 2'b01,
    XB_OP_WR    = 2'b10,
    XB_OP_WR_RD = 2'b11
  } xb_op_e;

  function automatic int xb_clog2(input int value);
    int r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/xb_fifo_ram.sv
// Simple dual-port RAM: synchronous write, registered synchronous read.
// Storage is never reset; only the read register clears on reset.
module xb_fifo_ram
  import xb_pkg::*;
#(
  parameter int WIDTH = XB_SIZE,
  parameter int DEPTH = 2 ** XB_DEF_ADDR_W,
  localparam int AW   = xb_clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/xb_msg_fifo.sv
// Single-clock standard-read message FIFO with registered status flags.
// Optional underflow pulse output enabled by defining XB_FIFO_UNDERFLOW_EN.
module xb_msg_fifo
  import xb_pkg::*;
#(
  parameter int WIDTH        = XB_SIZE,
  parameter int ADDR_W       = XB_DEF_ADDR_W,
  parameter int AFULL_MARGIN = XB_DEF_AFULL_MARGIN,
  parameter int DELAY        = 1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  output logic             full,
  output logic             almost_full,
  output logic             overflow,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
`ifdef XB_FIFO_UNDERFLOW_EN
  output logic             underflow,
`endif
  output logic             empty
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W + 1)'(AFULL_MARGIN);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count, count_nxt;
  logic              wr_ok, rd_ok;
  xb_op_e            op;

  // Acceptance uses the registered flags, so a read on a full queue
  // never frees a slot for a write on the same edge (and vice versa).
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  assign op    = xb_op_e'({wr_ok, rd_ok});

  always_comb begin
    count_nxt = count;
    case (op)
      XB_OP_WR: count_nxt = count + 1'b1;
      XB_OP_RD: count_nxt = count - 1'b1;
      default:  count_nxt = count;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full        <= FALSE;
      empty       <= TRUE;
      almost_full <= FALSE;
      overflow    <= FALSE;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count       <= count_nxt;
      full        <= (count_nxt == DEPTH_CNT);
      empty       <= (count_nxt == '0);
      almost_full <= ((DEPTH_CNT - count_nxt) <= AFULL_CNT);
      overflow    <= wr_en && full;
    end
  end

`ifdef XB_FIFO_UNDERFLOW_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) underflow <= FALSE;
    else          underflow <= rd_en && empty;
  end
`endif

  xb_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (din),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr),
    .rd_data (dout)
  );

endmodule

// File: tb/tb_xb_msg_fifo.sv
// Directed self-checking bench for xb_msg_fifo at DEPTH=16, AFULL_MARGIN=4.
module tb_xb_msg_fifo;

  localparam int WIDTH = 32;

  logic             CLK = 1'b0;
  logic             RESET_N = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic             full, almost_full, overflow, empty;
  logic [WIDTH-1:0] dout;
`ifdef XB_FIFO_UNDERFLOW_EN
  logic             underflow;
`endif

  int checks = 0;
  int failures = 0;

  xb_msg_fifo #(
    .WIDTH        (WIDTH),
    .ADDR_W       (4),
    .AFULL_MARGIN (4),
    .DELAY        (1)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .din         (din),
    .wr_en       (wr_en),
    .full        (full),
    .almost_full (almost_full),
    .overflow    (overflow),
    .rd_en       (rd_en),
    .dout        (dout),
`ifdef XB_FIFO_UNDERFLOW_EN
    .underflow   (underflow),
`endif
    .empty       (empty)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    din = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_val(tag, dout, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q[$];
    logic [31:0] e;

    // Reset then idle
    RESET_N = 1'b0;
    repeat (3) tick();
    check_val("rst_empty", 32'(empty), 32'd1);
    check_val("rst_full", 32'(full), 32'd0);
    check_val("rst_afull", 32'(almost_full), 32'd0);
    check_val("rst_ovf", 32'(overflow), 32'd0);
    check_val("rst_dout", dout, 32'h0);
    RESET_N = 1'b1;
    tick();
    rd_en = 1'b1;
    tick();
    tick();
    rd_en = 1'b0;
    check_val("idle_rd_dout", dout, 32'h0);
    check_val("idle_rd_empty", 32'(empty), 32'd1);
`ifdef XB_FIFO_UNDERFLOW_EN
    check_val("underflow_pulse", 32'(underflow), 32'd1);
    tick();
    check_val("underflow_clear", 32'(underflow), 32'd0);
`endif

    // Ordering
    for (int i = 1; i <= 5; i++) push(32'h1000_0000 + 32'(i));
    check_val("ord_not_empty", 32'(empty), 32'd0);
    for (int i = 1; i <= 5; i++) pop_chk("ord_data", 32'h1000_0000 + 32'(i));
    check_val("ord_empty", 32'(empty), 32'd1);

    // Fill and flags, including the almost_full threshold edge
    for (int i = 0; i < 11; i++) push(32'h2000_0000 + 32'(i));
    check_val("afull_at11", 32'(almost_full), 32'd0);
    push(32'h2000_000B);
    check_val("afull_at12", 32'(almost_full), 32'd1);
    check_val("full_at12", 32'(full), 32'd0);
    for (int i = 12; i < 16; i++) push(32'h2000_0000 + 32'(i));
    check_val("full_at16", 32'(full), 32'd1);
    check_val("ovf_before", 32'(overflow), 32'd0);
    push(32'hDEAD_BEEF);
    check_val("ovf_pulse", 32'(overflow), 32'd1);
    tick();
    check_val("ovf_cleared", 32'(overflow), 32'd0);
    check_val("full_hold", 32'(full), 32'd1);
    pop_chk("drain_data", 32'h2000_0000);
    check_val("full_after_pop", 32'(full), 32'd0);
    for (int i = 1; i < 16; i++) pop_chk("drain_data", 32'h2000_0000 + 32'(i));
    check_val("drain_empty", 32'(empty), 32'd1);
    pop_chk("drain_extra", 32'h2000_000F);

    // Simultaneous read/write on a full queue
    for (int i = 0; i < 16; i++) push(32'h3000_0000 + 32'(i));
    din = 32'h0000_0BAD; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check_val("sim_full_dout", dout, 32'h3000_0000);
    check_val("sim_full_ovf", 32'(overflow), 32'd1);
    check_val("sim_full_full", 32'(full), 32'd0);
    check_val("sim_full_afull", 32'(almost_full), 32'd1);
    for (int i = 1; i < 16; i++) pop_chk("sim_full_drain", 32'h3000_0000 + 32'(i));
    check_val("sim_full_empty", 32'(empty), 32'd1);

    // Simultaneous read/write at count=8 for 10 cycles
    for (int i = 0; i < 8; i++) push(32'h4000_0000 + 32'(i));
    for (int i = 0; i < 10; i++) begin
      din = 32'h4000_0008 + 32'(i); wr_en = 1'b1; rd_en = 1'b1;
      tick();
      check_val("sim8_dout", dout, 32'h4000_0000 + 32'(i));
      check_val("sim8_afull", 32'(almost_full), 32'd0);
    end
    wr_en = 1'b0; rd_en = 1'b0;
    check_val("sim8_empty", 32'(empty), 32'd0);
    check_val("sim8_full", 32'(full), 32'd0);
    for (int i = 0; i < 8; i++) pop_chk("sim8_drain", 32'h4000_000A + 32'(i));
    check_val("sim8_end_empty", 32'(empty), 32'd1);

    // Wrap-around stream: count climbs to 4 and then stays there
    q.delete();
    for (int i = 0; i < 40; i++) begin
      din = 32'h5000_0000 + 32'(i); wr_en = 1'b1; rd_en = (i >= 4);
      tick();
      q.push_back(32'h5000_0000 + 32'(i));
      if (i >= 4) begin
        e = q.pop_front();
        check_val("wrap_dout", dout, e);
      end
      check_val("wrap_empty", 32'(empty), 32'd0);
      check_val("wrap_full", 32'(full), 32'd0);
    end
    wr_en = 1'b0; rd_en = 1'b0;
    while (q.size() > 0) begin
      e = q.pop_front();
      pop_chk("wrap_drain", e);
    end
    check_val("wrap_end_empty", 32'(empty), 32'd1);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 7; i++) push(32'h6000_0000 + 32'(i));
    check_val("arst_pre_empty", 32'(empty), 32'd0);
    #3;
    RESET_N = 1'b0;
    #1;
    check_val("arst_empty", 32'(empty), 32'd1);
    check_val("arst_full", 32'(full), 32'd0);
    check_val("arst_dout", dout, 32'h0);
    RESET_N = 1'b1;
    tick();
    pop_chk("arst_rd_dout", 32'h0);
    check_val("arst_rd_empty", 32'(empty), 32'd1);
    push(32'h7000_0001);
    pop_chk("arst_new_word", 32'h7000_0001);
    check_val("arst_final_empty", 32'(empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xb_msg_fifo.md
Name: xb_msg_fifo

Overview:
- Single-clock, synchronous-write / synchronous-read message FIFO carrying XB_SIZE-bit words between the application and the Xillybus stream logic.
- Reports status flags: full, almost_full, empty, and a sticky-free one-cycle overflow pulse.
- Standard (non-FWFT) read port, usable as the FPGA-to-host message queue or the host-loopback queue.

Parameters:
- WIDTH, 32, data word width (matches XB_SIZE).
- ADDR_W, 9, log2 of depth; DEPTH = 2**ADDR_W entries.
- AFULL_MARGIN, 4, almost_full asserts when free slots <= AFULL_MARGIN.
- DELAY, 1, simulation-only non-blocking assignment delay; no functional effect.

Ports:
- CLK  in  1  sole clock; all state changes on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- din  in  WIDTH  write data.
- wr_en  in  1  write request.
- full  out  1  no free slots.
- almost_full  out  1  free slots <= AFULL_MARGIN.
- overflow  out  1  previous-cycle write was rejected.
- rd_en  in  1  read request.
- dout  out  WIDTH  read data, registered.
- empty  out  1  no stored words.
- underflow  out  1  only with XB_FIFO_UNDERFLOW_EN.

Behaviour:
- Reset (RESET_N low, async assert; deassertion sampled on CLK):
  - wr_ptr = rd_ptr = count = 0.
  - empty = 1; full = 0, almost_full = 0, overflow = 0, dout = 0.
  - Memory contents are not cleared.
- Write acceptance:
  - A write is accepted when wr_en && !full (full as registered at the start of the cycle).
  - Accepted write: mem[wr_ptr] <= din; wr_ptr increments modulo DEPTH.
- Read acceptance:
  - A read is accepted when rd_en && !empty.
  - Accepted read: dout <= mem[rd_ptr] on that edge, valid from the next cycle; rd_ptr increments modulo DEPTH.
  - Read latency is 1 cycle.
  - dout holds its value when no read is accepted.
- Rejected requests:
  - wr_en while full: data dropped, no state change; overflow = 1 on the following cycle only.
  - rd_en while empty: ignored; dout unchanged.
- Simultaneous wr_en and rd_en:
  - Both accepted when neither flag blocks them; count unchanged.
  - When full: only the read is accepted; the write is rejected and overflow pulses.
  - When empty: only the write is accepted; the read is ignored and no data passes through in the same cycle.
- Count and flags:
  - count is ADDR_W+1 bits, range 0..DEPTH.
  - full = (count == DEPTH).
  - empty = (count == 0).
  - almost_full = (DEPTH - count) <= AFULL_MARGIN.
  - All flags are registered and computed from next-state count, so they are correct in the cycle after the causing edge.
- Pointer wrap: pointers wrap naturally with ADDR_W bits; ordering is preserved across wrap.
- Reset mid-operation: all stored words are discarded immediately, and flags return to their reset values asynchronously.

Optional Feature:
- Macro: XB_FIFO_UNDERFLOW_EN.
- Defined: output underflow pulses 1 for one cycle after any rd_en sampled while empty; reset value 0.
- Undefined: the port and its logic are absent; rd_en while empty is silently ignored.
- Core behaviour is identical either way.

Decomposition:
- Shared package xb_pkg:
  - XB_SIZE = 32.
  - log2 ceiling function.
  - TRUE/FALSE constants.
  - Default ADDR_W and AFULL_MARGIN.
- One sub-module, xb_fifo_ram: simple dual-port RAM with a synchronous write port and a synchronous registered read port, WIDTH x DEPTH.
- Pointer, count and flag logic stays in xb_msg_fifo.

Test Plan (ADDR_W=4, DEPTH=16, AFULL_MARGIN=4):
- Reset then idle:
  - RESET_N low for 3 cycles -> empty=1, full=0, almost_full=0, overflow=0, dout=0.
  - rd_en=1 for 2 cycles -> dout stays 0, empty stays 1.
- Ordering:
  - Write 0x1000_0001..0x1000_0005, then read 5 -> dout returns 0x1000_0001..0x1000_0005 in order, each one cycle after its rd_en.
  - empty=1 after the last read.
- Fill and flags:
  - Write 12 words -> almost_full=1, full=0.
  - Write 4 more (16 total) -> full=1.
  - Write 0xDEAD_BEEF -> overflow=1 for exactly one cycle; a subsequent full drain returns only the 16 original words.
- Simultaneous operations:
  - With count=16, wr_en=rd_en=1 -> read accepted, write dropped, overflow=1, count=15.
  - With count=8, both asserted for 10 cycles -> count stays 8, data order intact.
- Wrap-around: stream 40 incrementing words with interleaved reads, keeping count at or below 16 -> all 40 are read back in order, no flag glitches.
- Async reset mid-stream: with count=7, pulse RESET_N low between clock edges -> empty=1 and full=0 immediately; the next read returns nothing; the next write/read pair returns only the new word.
